// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner for the execute stage: iterative shift-add multiply and restoring
// divide, MTHI/MTLO writes, and the stall that covers in-flight operations.
module hilo_muldiv_ctrl #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        hilo_read,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] HI_OUT,
    output logic [31:0] LO_OUT
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [5:0] RUN_CYCLES = 6'(32 / BITS_PER_CYCLE);

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_dividend;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div_zero;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_mdop;
    logic        w_signed;
    logic        w_div;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [63:0] w_acc;
    logic [63:0] w_mcand;
    logic [31:0] w_mplier;
    logic [32:0] w_trial;
    logic [63:0] w_result;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? -v : v;
    endfunction

    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign w_is_mdop = (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
    assign w_signed  = (op == 3'd1) || (op == 3'd3);
    assign w_div     = (op == 3'd3) || (op == 3'd4);
    assign w_mag_a   = mag32(opA, w_signed);
    assign w_mag_b   = mag32(opB, w_signed);

    // One RUN cycle: divide keeps {remainder, dividend/quotient} in r_acc
    always_comb begin
        w_acc    = r_acc;
        w_mcand  = r_mcand;
        w_mplier = r_mplier;
        w_trial  = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (r_is_div) begin
                w_trial = w_acc[63:31] - {1'b0, r_mcand[31:0]};
                if (!w_trial[32]) w_acc = {w_trial[31:0], w_acc[30:0], 1'b1};
                else              w_acc = {w_acc[62:0], 1'b0};
            end else begin
                if (w_mplier[0]) w_acc = w_acc + w_mcand;
                w_mcand  = w_mcand << 1;
                w_mplier = w_mplier >> 1;
            end
        end
    end

    always_comb begin
        w_result = cneg64(r_acc, r_neg_q);
        if (r_is_div) begin
            if (r_div_zero) w_result = {r_dividend, 32'hFFFF_FFFF};
            else            w_result = {cneg32(r_acc[63:32], r_neg_r), cneg32(r_acc[31:0], r_neg_q)};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_dividend <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        if (w_is_mdop) begin
                            r_acc      <= w_div ? {32'b0, w_mag_a} : 64'b0;
                            r_mcand    <= {32'b0, (w_div ? w_mag_b : w_mag_a)};
                            r_mplier   <= w_mag_b;
                            r_dividend <= opA;
                            r_is_div   <= w_div;
                            r_neg_q    <= w_signed & (opA[31] ^ opB[31]);
                            r_neg_r    <= w_signed & w_div & opA[31];
                            r_div_zero <= (opB == 32'b0);
                            r_cnt      <= RUN_CYCLES;
                            r_state    <= S_RUN;
                        end else if (op == 3'd5) begin
                            r_hi <= opA;
                        end else if (op == 3'd6) begin
                            r_lo <= opA;
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc    <= w_acc;
                        r_mcand  <= w_mcand;
                        r_mplier <= w_mplier;
                        r_cnt    <= r_cnt - 6'd1;
                        if (r_cnt == 6'd1) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    if (!flush) begin
                        r_hi   <= w_result[63:32];
                        r_lo   <= w_result[31:0];
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign stall  = busy & (start | hilo_read);
    assign done   = r_done;
    assign HI_OUT = r_hi;
    assign LO_OUT = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: three instances (1, 2 and 4 bits per
// cycle) compared against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start;
    logic [2:0]  op;
    logic [31:0] opA, opB;
    logic        hilo_read, flush;
    logic [2:0]  busy, stall, done;
    logic [31:0] hi [3];
    logic [31:0] lo [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hilo_muldiv_ctrl #(.BITS_PER_CYCLE(1 << g)) u_dut (
            .CLK(clk), .RESET(rst), .start(start[g]), .op(op), .opA(opA), .opB(opB),
            .hilo_read(hilo_read), .flush(flush), .busy(busy[g]), .stall(stall[g]),
            .done(done[g]), .HI_OUT(hi[g]), .LO_OUT(lo[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int ndone [3] = '{0, 0, 0};
    logic [63:0] exp_q [3][$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {HI,LO} from plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            3'd1: p = 64'(sa * sb);
            3'd2: p = {32'b0, a} * {32'b0, b};
            3'd3: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            3'd4: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: p = '0;
        endcase
        return p;
    endfunction

    always @(negedge clk) begin
        logic [63:0] e;
        for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) begin
                ndone[i]++;
                if (exp_q[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done_inst%0d: got done=1 expected no pulse", i);
                end else begin
                    e = exp_q[i].pop_front();
                    chk($sformatf("result_inst%0d", i), {hi[i], lo[i]}, e);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int c = 0; c < 100; c++) begin
            if (busy === 3'b000) return;
            @(posedge clk); #1;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic start_only(input logic [2:0] mask, input logic [2:0] o,
                              input logic [31:0] a, input logic [31:0] b, input bit push);
        wait_idle();
        start = mask; op = o; opA = a; opB = b;
        if (push)
            for (int i = 0; i < 3; i++)
                if (mask[i]) exp_q[i].push_back(model(o, a, b));
        @(posedge clk); #1;
        start = 3'b000; op = 3'd0;
    endtask

    task automatic issue(input logic [2:0] mask, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        int cnt [3];
        int nd0 [3];
        nd0 = ndone;
        cnt = '{0, 0, 0};
        start_only(mask, o, a, b, 1'b1);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (busy[i]) cnt[i]++;
            if (busy === 3'b000) break;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                chk($sformatf("busy_len_inst%0d", i), 64'(cnt[i]), 64'(32 / (1 << i) + 1));
                chk($sformatf("done_count_inst%0d", i), 64'(ndone[i] - nd0[i]), 64'd1);
            end
        end
    endtask

    task automatic chk_all(input string name, input logic [63:0] exp);
        for (int i = 0; i < 3; i++) chk($sformatf("%s_inst%0d", name, i), {hi[i], lo[i]}, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] saved [3];
        logic [63:0] e;
        int          nd0 [3];
        bit          ok;
        logic [2:0]  o;
        logic [31:0] a, b;

        rst = 1'b1; start = '0; op = '0; opA = '0; opB = '0; hilo_read = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        hilo_read = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_hilo", {hi[i], lo[i]}, 64'd0);
            chk("reset_busy", 64'(busy[i]), 64'd0);
            chk("reset_done", 64'(done[i]), 64'd0);
            chk("idle_read_no_stall", 64'(stall[i]), 64'd0);
        end
        hilo_read = 1'b0;
        @(posedge clk); #1;

        issue(3'b111, 3'd1, 32'hFFFF_FFFD, 32'd7);
        chk_all("mult_m3x7", 64'hFFFF_FFFF_FFFF_FFEB);
        issue(3'b111, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk_all("multu_max", 64'hFFFF_FFFE_0000_0001);
        issue(3'b111, 3'd4, 32'd100, 32'd7);
        chk_all("divu_100_7", {32'd2, 32'd14});
        issue(3'b111, 3'd3, 32'hFFFF_FFF9, 32'd2);
        chk_all("div_m7_2", 64'hFFFF_FFFF_FFFF_FFFD);
        issue(3'b111, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk_all("div_ovf", 64'h0000_0000_8000_0000);
        issue(3'b111, 3'd4, 32'd5, 32'd0);
        chk_all("divu_by0", 64'h0000_0005_FFFF_FFFF);
        issue(3'b111, 3'd3, 32'hFFFF_FFF7, 32'd0);
        chk_all("div_by0", 64'hFFFF_FFF7_FFFF_FFFF);

        for (int n = 0; n < 24; n++) begin
            o = 3'($urandom_range(1, 4));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 28);
            issue(3'b111, o, a, b);
        end

        // MTLO / MTHI / reserved op in IDLE
        start = 3'b001; op = 3'd6; opA = 32'h0000_1234;
        @(posedge clk); #1;
        start = 3'b000;
        chk("mtlo_lo", 64'(lo[0]), 64'h1234);
        chk("mtlo_busy", 64'(busy[0]), 64'd0);
        start = 3'b111; op = 3'd5; opA = 32'hCAFE_F00D;
        @(posedge clk); #1;
        start = 3'b000;
        for (int i = 0; i < 3; i++) chk("mthi_hi", 64'(hi[i]), 64'hCAFE_F00D);
        saved[0] = {hi[0], lo[0]};
        start = 3'b001; op = 3'd7; opA = 32'h5555_5555;
        @(posedge clk); #1;
        start = 3'b000;
        chk("op7_ignored", {hi[0], lo[0]}, saved[0]);
        chk("op7_busy", 64'(busy[0]), 64'd0);

        // MFHI/MFLO during DIV stalls until the result is written
        e = model(3'd3, 32'hFFFF_FF9C, 32'd9);
        start_only(3'b001, 3'd3, 32'hFFFF_FF9C, 32'd9, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        hilo_read = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (busy[0]) chk("read_stall", 64'(stall[0]), 64'd1);
            else begin
                chk("read_unstall", 64'(stall[0]), 64'd0);
                chk("read_new_hilo", {hi[0], lo[0]}, e);
                chk("read_idle_inst2", 64'(stall[2]), 64'd0);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("read_timeout", 64'(busy[0]), 64'd0);
        @(posedge clk); #1;
        hilo_read = 1'b0;

        // Back-to-back: second MULT held while busy, operands changed mid-run
        start_only(3'b001, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        start = 3'b001; op = 3'd1; opA = 32'h0001_0001; opB = 32'hFFFF_0003;
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (busy[0]) chk("b2b_stall", 64'(stall[0]), 64'd1);
            else begin
                exp_q[0].push_back(model(3'd1, 32'h0001_0001, 32'hFFFF_0003));
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        start = 3'b000; op = 3'd0;
        if (ok) chk("b2b_accept", 64'(busy[0]), 64'd1);
        else chk("b2b_timeout", 64'(busy[0]), 64'd0);
        wait_idle();
        @(posedge clk); #1;

        // flush at RUN cycle 10
        for (int i = 0; i < 3; i++) saved[i] = {hi[i], lo[i]};
        nd0 = ndone;
        start_only(3'b011, 3'd2, 32'hDEAD_0001, 32'h0BAD_F00D, 1'b0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 2; i++) chk("flush_run_busy", 64'(busy[i]), 64'd0);
        repeat (40) @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk("flush_run_hilo", {hi[i], lo[i]}, saved[i]);
            chk("flush_run_nodone", 64'(ndone[i] - nd0[i]), 64'd0);
        end

        // flush together with start in IDLE
        start = 3'b111; op = 3'd5; opA = 32'hDEAD_BEEF; flush = 1'b1;
        @(posedge clk); #1;
        start = 3'b000; flush = 1'b0;
        for (int i = 0; i < 3; i++) chk("flush_idle_mthi", {hi[i], lo[i]}, saved[i]);

        // flush coinciding with FIX
        saved[0] = {hi[0], lo[0]};
        nd0 = ndone;
        start_only(3'b001, 3'd1, 32'h0000_0123, 32'h0000_0456, 1'b0);
        repeat (32) @(posedge clk);
        #1 flush = 1'b1;
        chk("fix_still_busy", 64'(busy[0]), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_fix_busy", 64'(busy[0]), 64'd0);
        chk("flush_fix_hilo", {hi[0], lo[0]}, saved[0]);
        @(posedge clk); #1;
        chk("flush_fix_nodone", 64'(ndone[0] - nd0[0]), 64'd0);

        // RESET mid-RUN
        start_only(3'b111, 3'd1, 32'h7654_3210, 32'h0FED_CBA9, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_hilo", {hi[i], lo[i]}, 64'd0);
            chk("midrst_busy", 64'(busy[i]), 64'd0);
            chk("midrst_done", 64'(done[i]), 64'd0);
        end
        issue(3'b111, 3'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFD);

        repeat (3) @(posedge clk); #1;
        for (int i = 0; i < 3; i++) chk("queue_drained", 64'(exp_q[i].size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
